// File: rtl/ps2_host_tx_if.sv
// ============================================================================
// Module      : ps2_host_tx_if
// Description : Command handshake and open-drain PS/2 line bundle for ps2_host_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
        input  tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
        output tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe
    );
endinterface

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter with open-drain enables.
//               Define PS2_HOST_TX_RETRY_EN to retry a failed frame twice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES        = 3150,
    parameter int START_TIMEOUT_CYCLES  = 472500,
    parameter int PACKET_TIMEOUT_CYCLES = 63000
) (
    input  wire logic    clk,
    input  wire logic    resetN,
    ps2_host_tx_if.slave bus
);

    localparam int c_TMAX_A = (START_TIMEOUT_CYCLES > PACKET_TIMEOUT_CYCLES) ?
                              START_TIMEOUT_CYCLES : PACKET_TIMEOUT_CYCLES;
    localparam int c_TMAX   = (c_TMAX_A > INHIBIT_CYCLES) ? c_TMAX_A : INHIBIT_CYCLES;
    localparam int c_TW     = $clog2(c_TMAX + 2);

    localparam logic [c_TW-1:0] c_TSAT     = '1;
    localparam logic [c_TW-1:0] c_INH_LAST = c_TW'(INHIBIT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_START_TO = c_TW'(START_TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_PKT_TO   = c_TW'(PACKET_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5,
        S_WAIT_IDLE = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t          r_state;
    logic [2:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic [c_TW-1:0] r_timer;
    logic [7:0]      r_shift;
    logic [3:0]      r_idx;
    logic            r_tx_ready;
    logic            r_tx_done;
    logic            r_tx_error;
    logic            r_busy;
    logic            r_clk_oe;
    logic            r_dat_oe;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]      r_retry;
`endif

    logic            w_fe;
    logic            w_clk_s;
    logic            w_dat_s;
    logic            w_parity;
    logic            w_fail;
    logic [c_TW-1:0] w_timer_inc;

    // r_clk_sync[2] is the previous synchronized sample used for edge detection
    assign w_clk_s     = r_clk_sync[1];
    assign w_dat_s     = r_dat_sync[1];
    assign w_fe        = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_parity    = ~^r_shift;
    assign w_timer_inc = (r_timer == c_TSAT) ? r_timer : r_timer + 1'b1;

    always_comb begin
        w_fail = 1'b0;
        case (r_state)
            S_START:                       w_fail = !w_fe && (r_timer >= c_START_TO);
            S_DATA, S_PARITY, S_WAIT_IDLE: w_fail = (r_timer >= c_PKT_TO);
            S_STOP:                        w_fail = (r_timer >= c_PKT_TO) || (w_fe && w_dat_s);
            default:                       w_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_timer    <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_tx_ready <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            r_busy     <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry    <= '0;
`endif
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], bus.ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_dat_in};
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;

            if (w_fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
                if (r_retry != 2'd2) begin
                    r_retry  <= r_retry + 1'b1;
                    r_state  <= S_INHIBIT;
                    r_timer  <= '0;
                    r_clk_oe <= 1'b1;
                    r_dat_oe <= 1'b0;
                end else
`endif
                begin
                    r_state    <= S_ERROR;
                    r_clk_oe   <= 1'b0;
                    r_dat_oe   <= 1'b0;
                    r_tx_error <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx_ready <= 1'b1;
                        if (bus.tx_valid && r_tx_ready) begin
                            r_shift    <= bus.tx_data;
                            r_state    <= S_INHIBIT;
                            r_timer    <= '0;
                            r_clk_oe   <= 1'b1;
                            r_dat_oe   <= 1'b0;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                            r_retry    <= '0;
`endif
                        end
                    end
                    S_INHIBIT: begin
                        if (r_timer == c_INH_LAST) begin
                            r_clk_oe <= 1'b0;
                            r_dat_oe <= 1'b1;
                            r_state  <= S_START;
                            r_timer  <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    S_START: begin
                        if (w_fe) begin
                            r_dat_oe <= ~r_shift[0];
                            r_idx    <= 4'd1;
                            r_state  <= S_DATA;
                            r_timer  <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    S_DATA: begin
                        r_timer <= w_timer_inc;
                        if (w_fe) begin
                            if (r_idx == 4'd8) begin
                                r_dat_oe <= ~w_parity;
                                r_state  <= S_PARITY;
                            end else begin
                                r_dat_oe <= ~r_shift[r_idx[2:0]];
                                r_idx    <= r_idx + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        r_timer <= w_timer_inc;
                        if (w_fe) begin
                            r_dat_oe <= 1'b0;
                            r_state  <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // NACK is caught by w_fail, so an edge here is an ACK
                        r_timer <= w_timer_inc;
                        if (w_fe) begin
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        r_timer <= w_timer_inc;
                        if (w_clk_s && w_dat_s) begin
                            r_tx_done <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_ERROR: begin
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx_ready   = r_tx_ready;
    assign bus.tx_done    = r_tx_done;
    assign bus.tx_error   = r_tx_error;
    assign bus.busy       = r_busy;
    assign bus.ps2_clk_oe = r_clk_oe;
    assign bus.ps2_dat_oe = r_dat_oe;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;
    localparam int INH  = 10;
    localparam int STO  = 200;
    localparam int PTO  = 2000;
    localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int NATT = 3;
`else
    localparam int NATT = 1;
`endif

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    ps2_host_tx_if bus();

    always #5 clk = ~clk;

    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (STO),
        .PACKET_TIMEOUT_CYCLES(PTO)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int run_len = 0;
    int inh_phases = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic prev_clk_oe = 1'b0;
    logic prev_busy   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (resetN) begin
            check("done_err_exclusive", 32'(bus.tx_done & bus.tx_error), 32'd0);
            if (bus.tx_ready) begin
                check("ready_not_busy", 32'(bus.busy), 32'd0);
                check("ready_oe_released", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
            end
            if (bus.tx_done) done_cnt++;
            if (bus.tx_error) begin
                err_cnt++;
                check("error_oe_released", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
            end
            if (bus.ps2_clk_oe) begin
                run_len++;
            end else if (prev_clk_oe) begin
                inh_phases++;
                check("inhibit_length", 32'(run_len), 32'(INH));
                check("start_bit_driven", 32'(bus.ps2_dat_oe), 32'd1);
                run_len = 0;
            end
            if (bus.busy && !prev_busy) acc_cnt++;
        end
        prev_clk_oe = bus.ps2_clk_oe;
        prev_busy   = bus.busy;
    end

    task automatic request(input logic [7:0] b, input bit hold);
        bit ok = 1'b0;
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.tx_ready) ok = 1'b1;
            else @(negedge clk);
        end
        check("accept_seen", 32'(ok), 32'd1);
        @(negedge clk);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic dev_frame(input int npulses, input bit ack, output logic [10:0] smp);
        bit seen = 1'b0;
        smp = '0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (bus.ps2_clk_in && !bus.ps2_dat_in) seen = 1'b1;
        end
        check("device_request_seen", 32'(seen), 32'd1);
        if (seen) begin
            repeat (HALF) @(negedge clk);
            smp[0] = bus.ps2_dat_in;
            for (int k = 1; k <= npulses; k++) begin
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                smp[k] = bus.ps2_dat_in;
                repeat (HALF) @(negedge clk);
            end
            if (npulses == 10) begin
                if (ack) dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_dat_low = 1'b0;
            end
        end
    endtask

    task automatic expect_done(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.tx_done) got = 1'b1;
        end
        bus.tx_valid = 1'b0;
        check(name, 32'(got), 32'd1);
        check("ready_low_on_done", 32'(bus.tx_ready), 32'd0);
        @(negedge clk);
        check("ready_after_done", 32'(bus.tx_ready), 32'd1);
    endtask

    task automatic send_ok(input logic [7:0] b, input string name);
        logic [10:0] smp;
        int d0;
        d0 = done_cnt;
        request(b, 1'b0);
        dev_frame(10, 1'b1, smp);
        check(name, 32'(smp), 32'(frame_of(b)));
        expect_done("done_pulse");
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] smp;
        logic [7:0]  b;
        int c, e0, d0, i0, a0;
        bit got;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.tx_ready, bus.tx_done, bus.tx_error, bus.busy,
                                    bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.tx_ready), 32'd1);

        // 0xED: literal frame pins the model
        d0 = done_cnt;
        i0 = inh_phases;
        request(8'hED, 1'b0);
        dev_frame(10, 1'b1, smp);
        check("frame_0xED_literal", 32'(smp), 32'b11111011010);
        expect_done("done_0xED");
        check("done_count_0xED", 32'(done_cnt - d0), 32'd1);
        check("inhibit_phases_0xED", 32'(inh_phases - i0), 32'd1);

        request(8'h00, 1'b0);
        dev_frame(10, 1'b1, smp);
        check("parity_0x00", 32'(smp[9]), 32'd1);
        check("frame_0x00", 32'(smp), 32'(frame_of(8'h00)));
        expect_done("done_0x00");

        request(8'h01, 1'b0);
        dev_frame(10, 1'b1, smp);
        check("parity_0x01", 32'(smp[9]), 32'd0);
        check("frame_0x01", 32'(smp), 32'(frame_of(8'h01)));
        expect_done("done_0x01");

        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom);
            send_ok(b, "frame_random");
        end

        // Device never clocks: error on START cycle 201
        e0 = err_cnt; d0 = done_cnt; i0 = inh_phases;
        request(8'h3C, 1'b0);
        c = -1; got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (k != 0) @(negedge clk);
            if (bus.ps2_clk_oe) c = -1;
            else c++;
            if (bus.tx_error) got = 1'b1;
        end
        check("timeout_error_seen", 32'(got), 32'd1);
        check("timeout_cycle", 32'(c), 32'd201);
        @(negedge clk);
        check("ready_after_error", 32'(bus.tx_ready), 32'd1);
        check("timeout_err_count", 32'(err_cnt - e0), 32'd1);
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_inhibits", 32'(inh_phases - i0), 32'(NATT));

        // Device NACKs every attempt
        e0 = err_cnt; d0 = done_cnt; i0 = inh_phases;
        request(8'hF4, 1'b0);
        for (int a = 0; a < NATT; a++) begin
            dev_frame(10, 1'b0, smp);
            check("frame_nack", 32'(smp), 32'(frame_of(8'hF4)));
        end
        repeat (10) @(negedge clk);
        check("nack_err_count", 32'(err_cnt - e0), 32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_inhibits", 32'(inh_phases - i0), 32'(NATT));
        check("ready_after_nack", 32'(bus.tx_ready), 32'd1);

        // Reset in the middle of the data bits
        request(8'h96, 1'b0);
        dev_frame(4, 1'b1, smp);
        @(negedge clk);
        check("pre_reset_dat_oe", 32'(bus.ps2_dat_oe), 32'd1);
        #2 resetN = 1'b0;
        #1 check("async_reset_oe", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", 32'(bus.tx_ready), 32'd1);
        send_ok(8'hFF, "frame_0xFF_after_reset");

        // tx_valid held and tx_data altered mid-frame
        a0 = acc_cnt;
        request(8'hA5, 1'b1);
        fork
            begin
                repeat (150) @(negedge clk);
                bus.tx_data = 8'h55;
            end
        join_none
        dev_frame(10, 1'b1, smp);
        check("frame_held_valid", 32'(smp), 32'(frame_of(8'hA5)));
        expect_done("done_held_valid");
        repeat (5) @(negedge clk);
        check("single_acceptance", 32'(acc_cnt - a0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
